// File: rtl/sort_frame_sequencer.sv
// Frame sequencer between the UART byte links and the sorting engine.
// Accepts a length-prefixed frame, feeds the sorter, and returns length + sorted bytes.
module sort_frame_sequencer #(
  parameter int DATA_W         = 8,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [DATA_W-1:0] sort_data_o,
  output logic              sort_valid_o,
  output logic              sort_last_o,
  input  logic              sort_ready_i,
  output logic              sort_abort_o,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic              res_valid_i,
  input  logic              res_last_i,
  output logic              res_ready_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] MAX_LEN_D = DATA_W'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RESP_HDR,
    ST_DRAIN
  } state_t;

  state_t            state, state_n;
  logic [7:0]        len, len_n;
  logic [7:0]        cnt, cnt_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [1:0]        err_code, err_code_n;

  logic              rx_ready, tx_valid, sort_valid, sort_last, sort_abort;
  logic              res_ready, frame_done, err;
  logic [DATA_W-1:0] tx_data, sort_data;
  logic              cnt_is_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      len      <= '0;
      cnt      <= '0;
      timer    <= '0;
      err_code <= '0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      cnt      <= cnt_n;
      timer    <= timer_n;
      err_code <= err_code_n;
    end
  end

  assign cnt_is_last = (cnt == (len - 8'd1));

  always_comb begin
    state_n    = state;
    len_n      = len;
    cnt_n      = cnt;
    timer_n    = timer;
    err_code_n = err_code;
    rx_ready   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    sort_data  = '0;
    sort_valid = 1'b0;
    sort_last  = 1'b0;
    sort_abort = 1'b0;
    res_ready  = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;

    case (state)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid_i) begin
          if ((rx_data_i != '0) && (rx_data_i <= MAX_LEN_D)) begin
            len_n   = 8'(rx_data_i);
            cnt_n   = '0;
            timer_n = '0;
            state_n = ST_LOAD;
          end else begin
            err        = 1'b1;
            err_code_n = 2'd1;
          end
        end
      end

      // rx stream passes straight through to the sorter; the timer restarts
      // on every accepted byte and counts every other cycle, stalled or not.
      ST_LOAD: begin
        sort_data  = rx_data_i;
        sort_valid = rx_valid_i;
        rx_ready   = sort_ready_i;
        sort_last  = cnt_is_last;
        if (rx_valid_i && sort_ready_i) begin
          timer_n = '0;
          if (cnt_is_last) begin
            cnt_n   = '0;
            state_n = ST_RESP_HDR;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else if (timer == TMR_LAST) begin
          sort_abort = 1'b1;
          err        = 1'b1;
          err_code_n = 2'd2;
          state_n    = ST_IDLE;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      ST_RESP_HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(len);
        if (tx_ready_i) state_n = ST_DRAIN;
      end

      // A mismatching byte is still forwarded before the frame is dropped.
      ST_DRAIN: begin
        tx_data   = res_data_i;
        tx_valid  = res_valid_i;
        res_ready = tx_ready_i;
        if (res_valid_i && tx_ready_i) begin
          cnt_n = cnt + 8'd1;
          if (cnt_is_last && res_last_i) begin
            frame_done = 1'b1;
            state_n    = ST_IDLE;
          end else if (cnt_is_last || res_last_i) begin
            err        = 1'b1;
            err_code_n = 2'd3;
            state_n    = ST_IDLE;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign rx_ready_o   = rx_ready   & ~rst_i;
  assign tx_data_o    = rst_i ? '0 : tx_data;
  assign tx_valid_o   = tx_valid   & ~rst_i;
  assign sort_data_o  = rst_i ? '0 : sort_data;
  assign sort_valid_o = sort_valid & ~rst_i;
  assign sort_last_o  = sort_last  & ~rst_i;
  assign sort_abort_o = sort_abort & ~rst_i;
  assign res_ready_o  = res_ready  & ~rst_i;
  assign busy_o       = (state != ST_IDLE) & ~rst_i;
  assign frame_done_o = frame_done & ~rst_i;
  assign err_o        = err        & ~rst_i;
  assign err_code_o   = rst_i ? '0 : err_code;

endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Bench for sort_frame_sequencer: PC source, behavioural sorter and tx sink
// models, with expected streams derived from the frame rules.
module tb_sort_frame_sequencer;

  typedef logic [7:0] bq_t[$];

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b0;
  logic [7:0] sort_data_o;
  logic       sort_valid_o, sort_last_o, sort_abort_o;
  logic       sort_ready_i = 1'b0;
  logic [7:0] res_data_i = '0;
  logic       res_valid_i = 1'b0, res_last_i = 1'b0;
  logic       res_ready_o, busy_o, frame_done_o, err_o;
  logic [1:0] err_code_o;

  sort_frame_sequencer #(
    .DATA_W(8),
    .MAX_LEN(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .sort_data_o(sort_data_o), .sort_valid_o(sort_valid_o), .sort_last_o(sort_last_o),
    .sort_ready_i(sort_ready_i), .sort_abort_o(sort_abort_o),
    .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_last_i(res_last_i),
    .res_ready_o(res_ready_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0, n_bad = 0;
  int cyc = 0, mode = 0, early_idx = -1, res_idx = 0;
  int obs_done = 0, obs_err = 0, obs_abort = 0, tx_seen = 0;
  int exp_done = 0, exp_err = 0;
  int last_sort_cyc = -1, abort_cyc = -1, err_cyc = -1;
  bit do_rst = 1'b1, rx_hold = 1'b0, res_hold = 1'b0, tx_wait = 1'b0;
  bit saw_busy = 1'b0, saw_sv = 1'b0;
  logic [7:0] tx_prev = '0;
  bq_t rx_q, s_in, s_res, exp_sd, exp_tx, pay;
  logic exp_sl[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bq_t sorted(input bq_t q);
    bq_t r;
    r = q;
    for (int i = 1; i < r.size(); i++) begin
      logic [7:0] key;
      int j;
      key = r[i];
      j = i - 1;
      while (j >= 0 && r[j] > key) begin
        r[j+1] = r[j];
        j--;
      end
      r[j+1] = key;
    end
    return r;
  endfunction

  task automatic flush_models();
    rx_q.delete(); s_in.delete(); s_res.delete();
    exp_sd.delete(); exp_sl.delete(); exp_tx.delete();
    rx_hold = 0; res_hold = 0; tx_wait = 0; res_idx = 0;
  endtask

  // Queue a legal frame of length n with payload from pay.
  task automatic send_frame(input int n);
    bq_t srt;
    rx_q.push_back(8'(n));
    exp_tx.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      rx_q.push_back(pay[i]);
      exp_sd.push_back(pay[i]);
      exp_sl.push_back(i == n - 1);
    end
    srt = sorted(pay);
    foreach (srt[i]) exp_tx.push_back(srt[i]);
    exp_done++;
  endtask

  task automatic step();
    bit rx_x, sort_x, tx_x, res_x;
    @(posedge clk_i);
    cyc++;
    #1;
    rst_i = do_rst;
    case (mode)
      0: begin sort_ready_i = 1'b1; tx_ready_i = 1'b1; end
      1: begin sort_ready_i = cyc[0]; tx_ready_i = cyc[0]; end
      default: begin
        sort_ready_i = ($urandom_range(3) != 0);
        tx_ready_i   = ($urandom_range(3) != 0);
      end
    endcase
    if (!rx_hold && rx_q.size() > 0 && (mode != 2 || $urandom_range(3) != 0)) rx_hold = 1;
    rx_valid_i = rx_hold;
    rx_data_i  = rx_hold ? rx_q[0] : 8'($urandom);
    if (!res_hold && s_res.size() > 0 && (mode != 2 || $urandom_range(3) != 0)) res_hold = 1;
    res_valid_i = res_hold;
    res_data_i  = res_hold ? s_res[0] : 8'($urandom);
    res_last_i  = res_hold && ((early_idx >= 0) ? (res_idx == early_idx) : (s_res.size() == 1));

    @(negedge clk_i);
    if (rst_i) begin
      chk("rst_outputs_zero", 32'({rx_ready_o, tx_data_o, tx_valid_o, sort_data_o, sort_valid_o,
          sort_last_o, sort_abort_o, res_ready_o, busy_o, frame_done_o, err_o, err_code_o}), 32'h0);
      flush_models();
      return;
    end
    rx_x   = rx_valid_i & rx_ready_o;
    sort_x = sort_valid_o & sort_ready_i;
    tx_x   = tx_valid_o & tx_ready_i;
    res_x  = res_valid_i & res_ready_o;
    saw_busy |= busy_o;
    saw_sv   |= sort_valid_o;

    if (tx_wait) begin
      chk("tx_hold_valid", 32'(tx_valid_o), 32'h1);
      chk("tx_hold_data", 32'(tx_data_o), 32'(tx_prev));
    end
    tx_wait = tx_valid_o & ~tx_ready_i;
    tx_prev = tx_data_o;

    if (sort_x) begin
      last_sort_cyc = cyc;
      if (exp_sd.size() == 0) chk("sort_extra", 32'(sort_data_o), 32'hFFFF_FFFF);
      else begin
        chk("sort_data", 32'(sort_data_o), 32'(exp_sd.pop_front()));
        chk("sort_last", 32'(sort_last_o), 32'(exp_sl.pop_front()));
      end
      s_in.push_back(sort_data_o);
      if (sort_last_o) begin
        s_res = sorted(s_in);
        s_in.delete();
        res_idx = 0;
      end
    end
    if (rx_x) begin
      void'(rx_q.pop_front());
      rx_hold = 0;
    end
    if (tx_x) begin
      tx_seen++;
      if (exp_tx.size() == 0) chk("tx_extra", 32'(tx_data_o), 32'hFFFF_FFFF);
      else chk("tx_data", 32'(tx_data_o), 32'(exp_tx.pop_front()));
    end
    if (res_x) begin
      void'(s_res.pop_front());
      res_hold = 0;
      res_idx++;
    end
    if (frame_done_o) obs_done++;
    if (sort_abort_o) begin
      obs_abort++;
      abort_cyc = cyc;
      s_in.delete();
    end
    if (err_o) begin
      obs_err++;
      err_cyc = cyc;
      s_res.delete();
      res_hold = 0;
    end
  endtask

  task automatic run_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_sd.size() == 0 && !rx_hold && !busy_o) break;
    end
    chk("queues_drained", 32'(rx_q.size() + exp_tx.size() + exp_sd.size()), 32'h0);
  endtask

  initial begin
    int d0, e0, t0, a0;
    logic [7:0] bad;

    // reset
    do_rst = 1;
    step(); step();
    do_rst = 0;
    step();
    chk("rst_rx_ready", 32'(rx_ready_o), 32'h1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err_code", 32'(err_code_o), 32'h0);

    // normal frame, then the same frame with toggling backpressure
    for (int m = 0; m < 2; m++) begin
      mode = m;
      d0 = obs_done; e0 = obs_err; t0 = tx_seen;
      pay = '{8'h09, 8'h02, 8'h07, 8'h01};
      send_frame(4);
      run_quiet(200);
      chk("normal_done", 32'(obs_done - d0), 32'h1);
      chk("normal_no_err", 32'(obs_err - e0), 32'h0);
      chk("normal_tx_count", 32'(tx_seen - t0), 32'h5);
    end

    // bad lengths: 0 and MAX_LEN+8
    mode = 0;
    e0 = obs_err; saw_busy = 0; saw_sv = 0;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h28);
    exp_err += 2;
    run_quiet(50);
    step();
    chk("badlen_err_cnt", 32'(obs_err - e0), 32'h2);
    chk("badlen_code", 32'(err_code_o), 32'h1);
    chk("badlen_busy", 32'(saw_busy), 32'h0);
    chk("badlen_sort_valid", 32'(saw_sv), 32'h0);
    chk("badlen_rx_ready", 32'(rx_ready_o), 32'h1);

    // inter-byte timeout, then a clean frame
    e0 = obs_err; a0 = obs_abort; abort_cyc = -1; err_cyc = -1; last_sort_cyc = -1;
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h05);
    exp_sd.push_back(8'h05);
    exp_sl.push_back(1'b0);
    exp_err++;
    run_quiet(80);
    chk("to_gap", 32'(abort_cyc - last_sort_cyc), 32'd16);
    chk("to_err_with_abort", 32'(err_cyc), 32'(abort_cyc));
    chk("to_abort_cnt", 32'(obs_abort - a0), 32'h1);
    chk("to_err_cnt", 32'(obs_err - e0), 32'h1);
    chk("to_code", 32'(err_code_o), 32'h2);
    d0 = obs_done;
    pay = '{8'h33, 8'h11, 8'h22};
    send_frame(3);
    run_quiet(200);
    chk("to_next_done", 32'(obs_done - d0), 32'h1);

    // sorter flags last one byte early
    d0 = obs_done; e0 = obs_err;
    early_idx = 1;
    rx_q.push_back(8'h03);
    pay = '{8'hC0, 8'h40, 8'h80};
    foreach (pay[i]) begin
      rx_q.push_back(pay[i]);
      exp_sd.push_back(pay[i]);
      exp_sl.push_back(i == 2);
    end
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h40);
    exp_tx.push_back(8'h80);
    exp_err++;
    run_quiet(200);
    early_idx = -1;
    chk("early_err_cnt", 32'(obs_err - e0), 32'h1);
    chk("early_code", 32'(err_code_o), 32'h3);
    chk("early_no_done", 32'(obs_done - d0), 32'h0);
    chk("early_idle", 32'(busy_o), 32'h0);

    // reset in the middle of DRAIN
    d0 = obs_done; e0 = obs_err;
    pay = '{8'h04, 8'h03, 8'h02, 8'h01};
    send_frame(4);
    tx_seen = 0;
    for (int i = 0; i < 100 && tx_seen < 3; i++) step();
    chk("rst_mid_reach", 32'(tx_seen), 32'h3);
    do_rst = 1;
    step();
    exp_done--;
    do_rst = 0;
    step();
    chk("rst_mid_rx_ready", 32'(rx_ready_o), 32'h1);
    chk("rst_mid_busy", 32'(busy_o), 32'h0);
    chk("rst_mid_code", 32'(err_code_o), 32'h0);
    chk("rst_mid_no_evt", 32'(obs_done - d0 + obs_err - e0), 32'h0);

    // randomized traffic with boundary lengths and interleaved bad headers
    mode = 2;
    d0 = obs_done; e0 = obs_err;
    for (int f = 0; f < 24; f++) begin
      int n;
      if (f % 5 == 2) begin
        bad = (f == 2) ? 8'd33 : (f == 7) ? 8'd0 : 8'($urandom_range(255, 33));
        rx_q.push_back(bad);
        exp_err++;
      end
      n = (f == 0) ? 1 : (f == 1) ? 32 : int'($urandom_range(32, 1));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      send_frame(n);
    end
    run_quiet(30000);
    chk("rand_done", 32'(obs_done - d0), 32'd24);
    chk("rand_err", 32'(obs_err - e0), 32'd5);
    chk("rand_code", 32'(err_code_o), 32'h1);

    chk("total_done", 32'(obs_done), 32'(exp_done));
    chk("total_err", 32'(obs_err), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_frame_sequencer.md
Name: sort_frame_sequencer

Overview:
- Frame-level controller between the UART byte streams (uart_rx output, uart_tx input) and the sorting engine.
- Frame format on both links: one length byte N, then N payload bytes.
- Accepts a length-prefixed frame from the PC and streams the N payload bytes into the sorter, tagging the final byte.
- Returns the length byte to the PC, then streams the N sorted bytes back.
- Enforces frame-length limits, an inter-byte receive timeout, and sorter result-count consistency.

Parameters:
- DATA_W, 8: byte width of all data ports.
- MAX_LEN, 32: largest legal N (1..255).
- TIMEOUT_CYCLES, 1200000: idle clk_i cycles allowed between payload bytes during LOAD (100 ms at 12 MHz).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. Synchronous, active-high.
- rx_data_i, in, DATA_W: byte from uart_rx.
- rx_valid_i, in, 1: rx byte valid.
- rx_ready_o, out, 1: sequencer accepts rx byte.
- tx_data_o, out, DATA_W: byte to uart_tx.
- tx_valid_o, out, 1: tx byte valid.
- tx_ready_i, in, 1: uart_tx accepts byte.
- sort_data_o, out, DATA_W: payload byte to sorter.
- sort_valid_o, out, 1: payload valid.
- sort_last_o, out, 1: current payload byte is byte N-1.
- sort_ready_i, in, 1: sorter accepts byte.
- sort_abort_o, out, 1: one-cycle pulse; sorter discards the partial frame.
- res_data_i, in, DATA_W: sorted byte from sorter.
- res_valid_i, in, 1: sorted byte valid.
- res_last_i, in, 1: sorter marks final result byte.
- res_ready_o, out, 1: sequencer accepts sorted byte.
- busy_o, out, 1: state is not IDLE.
- frame_done_o, out, 1: one-cycle pulse on a correctly completed frame.
- err_o, out, 1: one-cycle error pulse.
- err_code_o, out, 2: 1 = bad length, 2 = rx timeout, 3 = result count mismatch. Holds last code; 0 after reset.

Behaviour:
- Handshake: a transfer occurs on any cycle where valid and ready are both high. Valid sources hold data stable until the transfer.
- Registered state: state, len (8b), cnt (8b), timeout counter, err_code_o.
- Reset: while rst_i is high, every output is forced to 0. On the first edge, state=IDLE and cnt=len=timer=0. Reset mid-frame abandons the frame silently; no abort pulse, no error.
- IDLE:
  - rx_ready_o=1.
  - On rx transfer with 1<=rx_data_i<=MAX_LEN: len<=rx_data_i, cnt<=0, timer<=0, go to LOAD.
  - Any other value (0 or >MAX_LEN): byte consumed, err_o pulse, err_code_o<=1, stay in IDLE.
- LOAD (combinational pass-through, zero added latency):
  - sort_data_o=rx_data_i, sort_valid_o=rx_valid_i, rx_ready_o=sort_ready_i.
  - sort_last_o=(cnt==len-1).
  - Each transfer: cnt++, timer<=0.
  - Transfer with sort_last_o=1: cnt<=0, go to RESP_HDR.
  - Cycles with no transfer increment timer. When timer reaches TIMEOUT_CYCLES-1: sort_abort_o pulse, err_o pulse, err_code_o<=2, go to IDLE.
  - The timeout counts even while sort_ready_i=0.
- RESP_HDR:
  - tx_valid_o=1, tx_data_o=len. rx_ready_o=0, res_ready_o=0.
  - On tx transfer, go to DRAIN.
- DRAIN (pass-through):
  - tx_data_o=res_data_i, tx_valid_o=res_valid_i, res_ready_o=tx_ready_i. rx_ready_o=0.
  - Each transfer: cnt++.
  - Transfer with cnt==len-1 and res_last_i=1: frame_done_o pulse, go to IDLE.
  - Transfer where (cnt==len-1) XOR res_last_i: byte still forwarded, err_o pulse, err_code_o<=3, go to IDLE.
  - No timeout in DRAIN.
- Outputs not named in a state are 0 in that state.
- busy_o is high in LOAD, RESP_HDR and DRAIN.
- A new frame header can be accepted on the cycle after any return to IDLE.
- N=1: the first LOAD byte has sort_last_o=1.

Test Plan:
- Normal frame: rx 04,09,02,07,01 with sorter returning 01,02,07,09 (last on 09). Required: sort_last_o only on byte 01; tx sends 04,01,02,07,09; one frame_done_o; err_o never high.
- Backpressure: same frame with sort_ready_i and tx_ready_i toggling 1/0 each cycle. Required: identical byte sequences, no drops or duplicates, tx_data_o stable while tx_valid_o=1 and tx_ready_i=0.
- Bad length: rx 00, then 28h (with MAX_LEN=32). Required: two err_o pulses with err_code_o=1; state stays IDLE; busy_o=0; no sort_valid_o.
- Timeout (TIMEOUT_CYCLES=16 in the bench): rx 03,05 then silence. Required: sort_abort_o and err_o pulse exactly 16 cycles after the 05 transfer; err_code_o=2; a following valid frame completes normally.
- Early last: N=3, sorter asserts res_last_i on the 2nd byte. Required: both bytes forwarded, err_code_o=3, return to IDLE, no frame_done_o.
- Reset mid-DRAIN: assert rst_i for 1 cycle after 2 of 4 result bytes. Required: all outputs 0 during reset; IDLE with rx_ready_o=1 the next cycle; err_code_o=0.
